// File: rtl/sdram_arbiter_if.sv
// Bundle of every signal between the SDRAM command scheduler and its neighbours:
// the init unit, the refresh/write/read engines and the muxed SDRAM command bus.
interface sdram_arbiter_if #(
  parameter int ADDR_BITS = 12,
  parameter int BA_BITS   = 2
);
  logic                 init_done;
  logic [3:0]           init_cmd;
  logic [ADDR_BITS-1:0] init_addr;

  logic                 wr_req;
  logic                 rd_req;
  logic                 aref_done;
  logic                 wr_done;
  logic                 rd_done;

  logic [3:0]           aref_cmd;
  logic [3:0]           wr_cmd;
  logic [3:0]           rd_cmd;
  logic [ADDR_BITS-1:0] aref_addr;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [BA_BITS-1:0]   wr_ba;
  logic [BA_BITS-1:0]   rd_ba;

  logic                 aref_en;
  logic                 wr_en;
  logic                 rd_en;
  logic [3:0]           sdram_cmd;
  logic [BA_BITS-1:0]   sdram_ba;
  logic [ADDR_BITS-1:0] sdram_addr;
  logic                 ref_ovf;

  // Requesters (init unit and engines) drive the bus from this side.
  modport master (
    output init_done, init_cmd, init_addr,
    output wr_req, rd_req, aref_done, wr_done, rd_done,
    output aref_cmd, wr_cmd, rd_cmd, aref_addr, wr_addr, rd_addr, wr_ba, rd_ba,
    input  aref_en, wr_en, rd_en, sdram_cmd, sdram_ba, sdram_addr, ref_ovf
  );

  // The arbiter itself.
  modport slave (
    input  init_done, init_cmd, init_addr,
    input  wr_req, rd_req, aref_done, wr_done, rd_done,
    input  aref_cmd, wr_cmd, rd_cmd, aref_addr, wr_addr, rd_addr, wr_ba, rd_ba,
    output aref_en, wr_en, rd_en, sdram_cmd, sdram_ba, sdram_addr, ref_ovf
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command scheduler: periodic refresh timer, refresh/write/read arbitration with
// read/write round-robin, and a command/address mux driven from the registered state.
module sdram_arbiter #(
  parameter int ADDR_BITS = 12,
  parameter int BA_BITS   = 2,
  parameter int REF_CNT   = 1035,
  parameter int REF_WIDTH = 11
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  localparam logic [3:0]           CMD_NOP  = 4'b0111;
  localparam logic [REF_WIDTH-1:0] REF_LAST = REF_WIDTH'(REF_CNT - 1);

  state_t               state;
  logic [REF_WIDTH-1:0] ref_timer;
  logic                 ref_pending;
  logic                 last_wr;
  logic                 ref_ovf_r;
  logic                 ref_wrap;

  logic [3:0]           cmd_mux;
  logic [BA_BITS-1:0]   ba_mux;
  logic [ADDR_BITS-1:0] addr_mux;

  // The timer is held at zero until initialisation hands over the bus.
  assign ref_wrap = (state != ST_INIT) && (ref_timer == REF_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= ST_INIT;
      ref_timer   <= '0;
      ref_pending <= 1'b0;
      last_wr     <= 1'b0;
      ref_ovf_r   <= 1'b0;
    end else begin
      if (state != ST_INIT) begin
        if (ref_wrap) ref_timer <= '0;
        else          ref_timer <= ref_timer + 1'b1;
      end

      // A wrap on the same edge as the service keeps the new request alive.
      if (ref_wrap)
        ref_pending <= 1'b1;
      else if (state == ST_IDLE && ref_pending)
        ref_pending <= 1'b0;

      if (ref_wrap && ref_pending)
        ref_ovf_r <= 1'b1;

      case (state)
        ST_INIT: begin
          if (bus.init_done) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (ref_pending) begin
            state <= ST_AREF;
          end else if (bus.wr_req && bus.rd_req) begin
            if (last_wr) begin
              state   <= ST_READ;
              last_wr <= 1'b0;
            end else begin
              state   <= ST_WRITE;
              last_wr <= 1'b1;
            end
          end else if (bus.wr_req) begin
            state   <= ST_WRITE;
            last_wr <= 1'b1;
          end else if (bus.rd_req) begin
            state   <= ST_READ;
            last_wr <= 1'b0;
          end
        end
        ST_AREF: begin
          if (bus.aref_done) state <= ST_IDLE;
        end
        ST_WRITE: begin
          if (bus.wr_done) state <= ST_IDLE;
        end
        ST_READ: begin
          if (bus.rd_done) state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = '0;
    addr_mux = '0;
    case (state)
      ST_INIT: begin
        cmd_mux  = bus.init_cmd;
        addr_mux = bus.init_addr;
      end
      ST_AREF: begin
        cmd_mux  = bus.aref_cmd;
        addr_mux = bus.aref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = bus.wr_cmd;
        ba_mux   = bus.wr_ba;
        addr_mux = bus.wr_addr;
      end
      ST_READ: begin
        cmd_mux  = bus.rd_cmd;
        ba_mux   = bus.rd_ba;
        addr_mux = bus.rd_addr;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = '0;
        addr_mux = '0;
      end
    endcase
  end

  assign bus.aref_en    = (state == ST_AREF);
  assign bus.wr_en      = (state == ST_WRITE);
  assign bus.rd_en      = (state == ST_READ);
  assign bus.sdram_cmd  = cmd_mux;
  assign bus.sdram_ba   = ba_mux;
  assign bus.sdram_addr = addr_mux;
  assign bus.ref_ovf    = ref_ovf_r;

endmodule
